// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD result display: FSM states,
// 7-segment lookup and the add-3 correction used by the double-dabble.
package bcd_display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // bit0 = a ... bit6 = g, active-high
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Pre-shift correction: any nibble >= 5 would overflow past 9 when doubled.
    function automatic logic [7:0] dabble_adj(input logic [7:0] bcd);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = bcd[7:4];
        lo = bcd[3:0];
        if (hi >= 4'd5) hi = hi + 4'd3;
        if (lo >= 4'd5) lo = lo + 4'd3;
        return {hi, lo};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-high 7-segment pattern; non-decimal codes go blank.
module seg7_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) seg = SEG_LUT[bcd];
    end

endmodule

// File: rtl/bcd_display.sv
// Sequential double-dabble of a small binary result into two BCD digits,
// held in registers and decoded onto two 7-segment displays.
module bcd_display
    import bcd_display_pkg::*;
#(
    parameter int BIN_W    = 5,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic [6:0]       seg1,
    output logic [6:0]       seg0
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SR_W  = 8 + BIN_W;

    if (BIN_W < 1 || BIN_W > 6) begin : g_bad_width
        $error("bcd_display: BIN_W must be 1..6 so the result fits in two digits");
    end

    state_t           state;
    logic [BIN_W-1:0] bin_sr;
    logic [7:0]       bcd;
    logic [CNT_W-1:0] cnt;
    logic             valid;

    logic [7:0]       bcd_adj;
    logic [SR_W-1:0]  shifted;
    logic [CNT_W-1:0] cnt_nxt;
    logic [6:0]       seg1_raw;
    logic [6:0]       seg0_raw;

    always_comb begin
        bcd_adj = dabble_adj(bcd);
        shifted = {bcd_adj, bin_sr} << 1;
        cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            tens   <= 4'd0;
            ones   <= 4'd0;
            valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        bcd    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd    <= shifted[SR_W-1 -: 8];
                    bin_sr <= shifted[BIN_W-1:0];
                    cnt    <= cnt_nxt;
                    // Digits are only written on the final step, so the
                    // display never shows a partial conversion.
                    if (cnt_nxt == CNT_W'(BIN_W)) begin
                        tens  <= shifted[SR_W-1 -: 4];
                        ones  <= shifted[SR_W-5 -: 4];
                        valid <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    seg7_decoder u_dec_tens (.bcd(tens), .seg(seg1_raw));
    seg7_decoder u_dec_ones (.bcd(ones), .seg(seg0_raw));

    always_comb begin
        seg0 = valid ? seg0_raw : SEG_BLANK;
        seg1 = valid ? seg1_raw : SEG_BLANK;
        if (LZ_BLANK && tens == 4'd0) seg1 = SEG_BLANK;
    end

endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench for bcd_display: the driver queues expected digits and
// segments per accepted start, a negedge monitor checks every done pulse.
module tb_bcd_display;

    localparam int BIN_W = 5;

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [6:0] seg1;
        logic [6:0] seg0;
        logic [6:0] seg1_nz;
        int         done_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             busy, done, busy_nz, done_nz;
    logic [3:0]       tens, ones, tens_nz, ones_nz;
    logic [6:0]       seg1, seg0, seg1_nz, seg0_nz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];

    logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_display #(.BIN_W(BIN_W), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .tens(tens), .ones(ones),
        .seg1(seg1), .seg0(seg0)
    );

    bcd_display #(.BIN_W(BIN_W), .LZ_BLANK(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy_nz), .done(done_nz), .tens(tens_nz), .ones(ones_nz),
        .seg1(seg1_nz), .seg0(seg0_nz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected entry for a start accepted at the coming posedge.
    task automatic push(input logic [3:0] t, input logic [3:0] o,
                        input logic [6:0] s1, input logic [6:0] s0,
                        input logic [6:0] s1nz);
        exp_t e;
        e.tens = t; e.ones = o; e.seg1 = s1; e.seg0 = s0; e.seg1_nz = s1nz;
        e.done_cyc = cyc + 1 + BIN_W;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("tens", tens, e.tens);
                chk("ones", ones, e.ones);
                chk("seg1", seg1, e.seg1);
                chk("seg0", seg0, e.seg0);
                chk("seg1_nolz", seg1_nz, e.seg1_nz);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("timeout_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic conv(input logic [BIN_W-1:0] b, input logic [3:0] t,
                        input logic [3:0] o, input logic [6:0] s1,
                        input logic [6:0] s0, input logic [6:0] s1nz);
        @(negedge clk);
        bin = b; start = 1'b1;
        push(t, o, s1, s0, s1nz);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    initial begin
        int n;
        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tens", tens, 0);
        chk("rst_ones", ones, 0);
        chk("rst_seg0", seg0, 7'h00);
        chk("rst_seg1", seg1, 7'h00);
        chk("rst_seg1_nolz", seg1_nz, 7'h00);

        conv(5'd27, 4'd2, 4'd7, 7'h5B, 7'h07, 7'h5B);
        wait_idle(20);
        conv(5'd31, 4'd3, 4'd1, 7'h4F, 7'h06, 7'h4F);
        wait_idle(20);
        conv(5'd0, 4'd0, 4'd0, 7'h00, 7'h3F, 7'h3F);
        wait_idle(20);

        // 9 with an ignored retrigger and bin wiggle, then 20 in the done cycle
        conv(5'd9, 4'd0, 4'd9, 7'h00, 7'h6F, 7'h3F);
        @(negedge clk);
        bin = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bin = 5'd3;
        chk("hold_prev_ones", ones, 0);
        chk("hold_prev_seg0", seg0, 7'h3F);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done_9", done, 1);
        bin = 5'd20; start = 1'b1;
        push(4'd2, 4'd0, 7'h5B, 7'h3F, 7'h5B);
        @(negedge clk);
        start = 1'b0;
        wait_idle(20);

        // Abort by reset three cycles after accept
        @(negedge clk);
        bin = 5'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_seg0", seg0, 7'h00);
        chk("abort_seg1", seg1, 7'h00);
        chk("abort_tens", tens, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done, 0);
        conv(5'd15, 4'd1, 4'd5, 7'h06, 7'h6D, 7'h06);
        wait_idle(20);

        // Sweep with start held high: accepts every BIN_W+1 cycles
        for (int v = 0; v < 32; v++) begin
            logic [3:0] t, o;
            t = 4'(v / 10);
            o = 4'(v % 10);
            @(negedge clk);
            bin = 5'(v); start = 1'b1;
            push(t, o, (t == 0) ? 7'h00 : lut[t], lut[o], lut[t]);
            repeat (BIN_W) @(negedge clk);
        end
        start = 1'b0;
        wait_idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_display.md
# bcd_display

Result display stage downstream of the controller in the chip top. On a one-cycle `start` strobe (the controller's `show_result`), it captures the 5-bit binary `result` and converts it to two BCD digits with a sequential double-dabble (shift-and-add-3). It then latches the tens/ones digits and drives two 7-segment displays. A `busy`/`done` handshake lets the controller sequence further presses.

## Interface
- `BIN_W`, default 5: width of binary input. Legal range 1..6, so the maximum value 2^BIN_W-1 ≤ 99. An elaboration-time check fails otherwise.
- `LZ_BLANK`, default 1: when 1, blank the tens display while tens == 0.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  conversion request, sampled only in IDLE.
- `bin`  in  BIN_W  binary value, captured on the accepting edge.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when new digits are valid.
- `tens`  out  4  BCD tens digit (registered).
- `ones`  out  4  BCD ones digit (registered).
- `seg1`  out  7  tens display, active-high, bit0 = a … bit6 = g.
- `seg0`  out  7  ones display, same encoding.

## Operation
- States: IDLE, SHIFT.
- **IDLE**
  - `start` = 1 at edge k: capture `bin` into the shift register and clear the BCD scratch (8 bits).
  - Clear the step counter and go to SHIFT.
  - `start` = 0: stay in IDLE.
- **SHIFT**, one step per edge:
  - For each BCD nibble ≥ 5, add 3.
  - Then shift {bcd, bin_sr} left by 1 and increment the counter.
  - On the step where the counter reaches BIN_W: write the final nibbles to `tens`/`ones`, set the `valid` flag, set `done` for the next cycle, and return to IDLE.
- `start` in SHIFT is ignored. No queueing.
- `bin` changes after capture do not affect the result.
- **Segment encoding** for digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Codes 10–15 map to 00, which is unreachable in legal use.
- **Blanking:**
  - Before the first completed conversion (`valid` = 0), `seg0` = `seg1` = 00.
  - If LZ_BLANK = 1 and `tens` = 0, `seg1` = 00.
  - `seg0` always shows `ones` once `valid` = 1, so 0 displays as 3F.
- Segment outputs are combinational decodes of the registered digits plus `valid`. No extra latency.

## Timing
- **Reset values:** state IDLE, `busy` 0, `done` 0, `tens` 0, `ones` 0, `valid` 0, `seg0` 00, `seg1` 00.
- `start` high at edge k gives:
  - `busy` = 1 during cycles after edges k … k+BIN_W−1.
  - `tens`/`ones` update at edge k+BIN_W.
  - `done` = 1 for exactly the cycle after edge k+BIN_W.
  - `busy` = 0 in that same cycle.
- Latency: BIN_W cycles from the accepting edge to valid digits (5 with defaults).
- Back-to-back: `start` may be high during the `done` cycle and is accepted at that edge. Sustained throughput is one conversion per BIN_W+1 cycles.
- `start` held high continuously re-triggers every BIN_W+1 cycles.
- **Reset mid-conversion** (`rst` at any edge): the FSM aborts to IDLE.
  - Outputs return to reset values.
  - No `done` pulse occurs for the aborted conversion.
  - `rst` takes priority over `start` at the same edge.
- Previous digits stay displayed throughout a conversion. There is no flicker or intermediate values.

## Structure
- Package `bcd_display_pkg` holds:
  - state enum (IDLE, SHIFT)
  - `SEG_LUT[0:9]` constant array
  - `SEG_BLANK` = 7'h00
- Sub-module `seg7_decoder` (4-bit BCD → 7-bit segments, 10–15 → blank), instantiated twice. Blanking muxes live in `bcd_display`.
- Step counter width is $clog2(BIN_W+1).
- The top-level instantiation connects `start` ← `show_result`, `bin` ← `result`, and outputs to `tens`/`ones`/`seg1`/`seg0`.

## Test plan
- Reset, then idle 10 cycles → `busy` 0, `done` 0, `tens`/`ones` 0, `seg0` = `seg1` = 00.
- `bin` = 27, one-cycle `start` → `done` exactly 5 cycles after the accepting edge; `tens` = 2, `ones` = 7, `seg1` = 5B, `seg0` = 07.
- `bin` = 31 → `tens` = 3, `ones` = 1, `seg1` = 4F, `seg0` = 06. Then `bin` = 0 → `seg0` = 3F, `seg1` = 00 (LZ_BLANK = 1); with LZ_BLANK = 0, `seg1` = 3F.
- `start` with `bin` = 9:
  - Pulse `start` again with `bin` = 20 two cycles later → ignored; the result is 0/9.
  - Change `bin` mid-busy → no effect.
  - `start` with `bin` = 20 during the `done` cycle → accepted; `done` again 6 cycles after the first `done`, giving 2/0.
- `start` with `bin` = 15, `rst` asserted 3 cycles later → IDLE next cycle, `busy` 0, `seg0`/`seg1` 00, no `done`. A fresh `start` then converts normally.
- Exhaustive sweep `bin` = 0..31 against a reference model, back-to-back `start` → every `done` matches `bin`/10 and `bin`%10, with a spacing of 6 cycles.
